// File: rtl/pip_if_rv32_pkg.sv
// Shared definitions for the RV32 instruction-fetch stage: fetch FSM encoding,
// reset/NOP constants, fetch-buffer entry layout and base opcode decode values.
package pip_if_rv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013;
    localparam int          FIFO_W           = 64;

    // RV32I major opcodes as seen by the decode stage
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pip_fifo2.sv
// Two-entry fetch buffer. Entry 0 is always the head and is a register, so the
// head word reaches the decode stage straight from flops.
module pip_fifo2
    import pip_if_rv32_pkg::*;
#(
    parameter int           W          = FIFO_W,
    parameter logic [W-1:0] EMPTY_WORD = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] entry_reg  [2];
    logic [W-1:0] entry_next [2];
    logic [1:0]   count_reg;
    logic [1:0]   count_next;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    always_comb begin
        entry_next = entry_reg;
        count_next = count_reg;
        if (flush) begin
            count_next    = 2'd0;
            entry_next[0] = EMPTY_WORD;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_reg == 2'd0) entry_next[0] = push_data;
                    else                   entry_next[1] = push_data;
                    count_next = count_reg + 2'd1;
                end
                2'b01: begin
                    // head falls back to the idle word when the buffer drains
                    entry_next[0] = (count_reg == 2'd2) ? entry_reg[1] : EMPTY_WORD;
                    count_next    = count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd2) begin
                        entry_next[0] = entry_reg[1];
                        entry_next[1] = push_data;
                    end else begin
                        entry_next[0] = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_reg[0] <= EMPTY_WORD;
            entry_reg[1] <= '0;
            count_reg    <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) entry_reg[i] <= entry_next[i];
            count_reg <= count_next;
        end
    end

    assign head_data = entry_reg[0];
    assign full      = (count_reg == 2'd2);
    assign empty     = (count_reg == 2'd0);

endmodule

// File: rtl/pip_if_rv32.sv
// RV32 instruction-fetch stage: single-outstanding I-cache requester feeding a
// two-entry buffer toward decode, with branch redirect and stale-response drop.
module pip_if_rv32
    import pip_if_rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    output logic [31:0] oICacheADDR,
    output logic        oICacheREQ,
    input  logic [31:0] iICacheDATA,
    input  logic        iICacheVALID,
    input  logic        iBranchTAKEN,
    input  logic [31:0] iBranchADDR,
    input  logic        iStall,
    output logic [31:0] oPCADDR,
    output logic [31:0] oINSTR,
    output logic        oVALID
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  fetch_pc_next;
    logic [31:0]  drop_addr_reg;
    logic [31:0]  drop_addr_next;

    logic         push;
    logic         pop;
    logic         flush;
    logic         fifo_full;
    logic         fifo_empty;
    logic         credit_after_push;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_reg     <= ST_IDLE;
            fetch_pc_reg  <= RESET_VECTOR;
            drop_addr_reg <= RESET_VECTOR;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            drop_addr_reg <= drop_addr_next;
        end
    end

    // A push leaves a free entry only if the buffer was empty or pops this cycle
    assign credit_after_push = fifo_empty || (pop && !fifo_full);

    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        drop_addr_next = drop_addr_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (iBranchTAKEN) begin
                    state_next     = iICacheVALID ? ST_REQ : ST_DROP;
                    drop_addr_next = fetch_pc_reg;
                end else if (iICacheVALID) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = credit_after_push ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (iBranchTAKEN || pop) state_next = ST_REQ;
            end
            ST_DROP: begin
                if (!iBranchTAKEN && iICacheVALID) state_next = ST_REQ;
            end
            default: state_next = ST_IDLE;
        endcase
        if (iBranchTAKEN) fetch_pc_next = word_align(iBranchADDR);
    end

    always_comb begin
        oICacheREQ  = (state_reg == ST_REQ) || (state_reg == ST_DROP);
        oICacheADDR = (state_reg == ST_DROP) ? drop_addr_reg : fetch_pc_reg;
        push        = (state_reg == ST_REQ) && iICacheVALID && !iBranchTAKEN;
        pop         = !fifo_empty && !iStall;
        flush       = iBranchTAKEN;
    end

    assign push_entry = '{pc: fetch_pc_reg, instr: iICacheDATA};

    pip_fifo2 #(
        .W          (FIFO_W),
        .EMPTY_WORD ({32'h0000_0000, NOP_INSTR})
    ) u_fifo (
        .clk       (iCLK),
        .rst_n     (iRSTn),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign oVALID  = !fifo_empty;
    assign oPCADDR = head_entry.pc;
    assign oINSTR  = head_entry.instr;

endmodule

// File: tb/tb_pip_if_rv32.sv
// Randomized bench for pip_if_rv32 against a program-order stream model with
// a variable-latency I-cache responder and directed redirect/reset scenarios.
module tb_pip_if_rv32;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        iCLK = 1'b0;
    logic        iRSTn;
    logic [31:0] oICacheADDR;
    logic        oICacheREQ;
    logic [31:0] iICacheDATA;
    logic        iICacheVALID;
    logic        iBranchTAKEN;
    logic [31:0] iBranchADDR;
    logic        iStall;
    logic [31:0] oPCADDR;
    logic [31:0] oINSTR;
    logic        oVALID;

    pip_if_rv32 dut (
        .iCLK         (iCLK),
        .iRSTn        (iRSTn),
        .oICacheADDR  (oICacheADDR),
        .oICacheREQ   (oICacheREQ),
        .iICacheDATA  (iICacheDATA),
        .iICacheVALID (iICacheVALID),
        .iBranchTAKEN (iBranchTAKEN),
        .iBranchADDR  (iBranchADDR),
        .iStall       (iStall),
        .oPCADDR      (oPCADDR),
        .oINSTR       (oINSTR),
        .oVALID       (oVALID)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0;
    int n_err = 0;

    // Stream model: buffered word count, next PC to present, next PC to fetch,
    // and whether the outstanding request predates a redirect.
    int          cnt;
    logic [31:0] exp_pc;
    logic [31:0] fetch_pc;
    logic        stale;
    logic [31:0] stale_addr;
    logic        idle;
    int          wait_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input int dly, input logic fv);
        logic req_exp, vld, pop, ack;
        req_exp = idle ? 1'b0 : (stale || cnt < 2);
        check_val("req", oICacheREQ, req_exp);
        if (req_exp) check_val("addr", oICacheADDR, stale ? stale_addr : fetch_pc);
        check_val("valid", oVALID, cnt > 0);
        if (cnt > 0) begin
            check_val("pc", oPCADDR, exp_pc);
            check_val("instr", oINSTR, mem_word(exp_pc));
        end else begin
            check_val("nop", oINSTR, NOP);
        end

        vld = 1'b0;
        if (oICacheREQ) begin
            if (wait_cnt < 0) wait_cnt = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
            if (wait_cnt == 0) begin
                vld = 1'b1;
                wait_cnt = -1;
            end else begin
                wait_cnt--;
            end
        end
        if (fv) begin
            vld = 1'b1;
            if (oICacheREQ) wait_cnt = -1;
        end
        iICacheVALID = vld;
        iICacheDATA  = (vld && oICacheREQ) ? mem_word(oICacheADDR) : $urandom;
        iStall       = st;
        iBranchTAKEN = br;
        iBranchADDR  = tgt;

        pop = (cnt > 0) && !st;
        ack = req_exp && vld;
        if (pop) begin
            $display("pop pc=%h instr=%h", exp_pc, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            cnt--;
        end
        if (br) begin
            if (!stale && req_exp && !vld) begin
                stale      = 1'b1;
                stale_addr = fetch_pc;
            end
            cnt      = 0;
            fetch_pc = {tgt[31:2], 2'b00};
            exp_pc   = fetch_pc;
            $display("branch tgt=%h", fetch_pc);
        end else if (ack) begin
            if (stale) stale = 1'b0;
            else begin
                cnt++;
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        idle = 1'b0;
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic do_reset(input logic late_vld);
        iRSTn        = 1'b0;
        iBranchTAKEN = 1'b0;
        iStall       = 1'b0;
        iICacheVALID = late_vld;
        iICacheDATA  = 32'hDEAD_BEEF;
        @(posedge iCLK);
        @(negedge iCLK);
        check_val("rst_req", oICacheREQ, 1'b0);
        check_val("rst_addr", oICacheADDR, 32'h0);
        check_val("rst_valid", oVALID, 1'b0);
        check_val("rst_pc", oPCADDR, 32'h0);
        check_val("rst_instr", oINSTR, NOP);
        $display("reset applied");
        iRSTn = 1'b1;
        iICacheVALID = 1'b0;
        cnt = 0; exp_pc = 32'h0; fetch_pc = 32'h0; stale = 1'b0;
        stale_addr = 32'h0; idle = 1'b1; wait_cnt = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lv [8];
        logic [31:0] lp [8];
        logic [31:0] base;
        logic        found;
        logic        saw8;
        int          w, k;

        iRSTn = 1'b0; iICacheVALID = 1'b0; iICacheDATA = 32'h0;
        iBranchTAKEN = 1'b0; iBranchADDR = 32'h0; iStall = 1'b0;
        repeat (2) @(negedge iCLK);

        // reset release, zero-wait cache: 0, 4, 8 back to back
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            lv[i] = oVALID; lp[i] = oPCADDR;
            step(1'b0, 1'b0, 32'h0, 0, 1'b0);
        end
        check_val("b_first_req_addr_valid", lv[1], 1'b0);
        check_val("b_v0", lv[2], 1'b1); check_val("b_pc0", lp[2], 32'h0);
        check_val("b_v1", lv[3], 1'b1); check_val("b_pc1", lp[3], 32'h4);
        check_val("b_v2", lv[4], 1'b1); check_val("b_pc2", lp[4], 32'h8);

        // stall five cycles: fill to two, request drops, then resume cleanly
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 0, 1'b0);
        check_val("c_hold_req", oICacheREQ, 1'b0);
        check_val("c_hold_valid", oVALID, 1'b1);
        base = exp_pc;
        for (int i = 0; i < 3; i++) begin
            lv[i] = oVALID; lp[i] = oPCADDR;
            step(1'b0, 1'b0, 32'h0, 0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            check_val("c_release_valid", lv[i], 1'b1);
            check_val("c_release_pc", lp[i], base + 32'(4 * i));
        end

        // branch to 0x100 from HOLD (nothing outstanding)
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 0, 1'b0);
        check_val("d_addr", oICacheADDR, 32'h100);
        check_val("d_req", oICacheREQ, 1'b1);
        check_val("d_valid", oVALID, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (oVALID) begin
                found = 1'b1;
                check_val("d_first_pc", oPCADDR, 32'h100);
            end else step(1'b0, 1'b0, 32'h0, 0, 1'b0);
        end
        check_val("d_found", found, 1'b1);

        // branch to 0x200 while the 0x8 request has waited three cycles
        do_reset(1'b0);
        w = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (oICacheREQ && oICacheADDR == 32'h8) w++;
            if (w == 4) begin
                found = 1'b1;
                step(1'b0, 1'b1, 32'h200, 6, 1'b0);
            end else begin
                step(1'b0, 1'b0, 32'h0, (oICacheADDR == 32'h8) ? 6 : 0, 1'b0);
            end
        end
        check_val("e_reached", found, 1'b1);
        saw8 = 1'b0; found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (oVALID && oPCADDR == 32'h8) saw8 = 1'b1;
            if (!found && oICacheREQ && oICacheADDR != 32'h8) begin
                found = 1'b1;
                check_val("e_next_addr", oICacheADDR, 32'h200);
            end
            step(1'b0, 1'b0, 32'h0, 0, 1'b0);
        end
        check_val("e_found", found, 1'b1);
        check_val("e_no_8", saw8, 1'b0);

        // redirect to unaligned 0x3 while fetching 0xFFFF_FFFC
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (oICacheREQ && oICacheADDR == 32'hFFFF_FFFC && !stale) begin
                found = 1'b1;
                step(1'b0, 1'b1, 32'h3, 3, 1'b0);
            end else step(1'b0, 1'b0, 32'h0, 3, 1'b0);
        end
        check_val("f_reached", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (oICacheREQ && !stale) begin
                found = 1'b1;
                check_val("f_addr_aligned", oICacheADDR, 32'h0);
            end else step(1'b0, 1'b0, 32'h0, 0, 1'b0);
        end
        check_val("f_found", found, 1'b1);

        // sequential wrap past the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 0, 1'b0);
        k = 0;
        for (int i = 0; i < 16 && k < 3; i++) begin
            if (oVALID) begin lp[k] = oPCADDR; k++; end
            step(1'b0, 1'b0, 32'h0, 0, 1'b0);
        end
        check_val("w_count", k, 3);
        check_val("w_pc0", lp[0], 32'hFFFF_FFF8);
        check_val("w_pc1", lp[1], 32'hFFFF_FFFC);
        check_val("w_pc2", lp[2], 32'h0);

        // reset with a request outstanding, late response ignored
        step(1'b0, 1'b0, 32'h0, 5, 1'b0);
        step(1'b0, 1'b0, 32'h0, 5, 1'b0);
        check_val("g_outstanding", oICacheREQ, 1'b1);
        do_reset(1'b1);
        step(1'b0, 1'b0, 32'h0, -1, 1'b1);
        check_val("g_stale_ignored", oVALID, 1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic        st, br, fv;
            logic [31:0] tgt;
            st = ($urandom_range(0, 99) < 35);
            br = ($urandom_range(0, 99) < 4);
            fv = !oICacheREQ && ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'($urandom_range(0, 255));
                default: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            step(st, br, tgt, -1, fv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pip_if_rv32.md
PIP_IF_RV32 -- requirements
Module: pip_if_rv32

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), SHALL be the value of oINSTR when no instruction is valid.
REQ-003 iCLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 iRSTn  in  1  SHALL be the synchronous, active-low reset.
REQ-005 oICacheADDR  out  32  SHALL carry the word-aligned fetch address.
REQ-006 oICacheREQ  out  1  SHALL be the fetch request, held until acknowledged.
REQ-007 iICacheDATA  in  32  SHALL carry the instruction word, valid when iICacheVALID=1.
REQ-008 iICacheVALID  in  1  SHALL be a one-cycle response pulse that acknowledges the outstanding request.
REQ-009 iBranchTAKEN  in  1  SHALL be a one-cycle redirect pulse.
REQ-010 iBranchADDR  in  32  SHALL carry the redirect target; bits [1:0] SHALL be ignored.
REQ-011 iStall  in  1  SHALL be high when the decode stage cannot accept an instruction.
REQ-012 oPCADDR  out  32  SHALL carry the PC of the presented instruction and feeds the decode stage iPCADDR.
REQ-013 oINSTR  out  32  SHALL carry the presented instruction and feeds the decode stage iCacheDATA.
REQ-014 oVALID  out  1  SHALL be high when oINSTR/oPCADDR hold a live instruction.

Function
REQ-015 Fetch FSM states: IDLE, REQ, HOLD, DROP.
REQ-016 IDLE SHALL last one cycle after reset release, then go to REQ.
REQ-017 In REQ, oICacheREQ=1 and oICacheADDR=fetchPC; both SHALL be held stable until iICacheVALID=1.
REQ-018 Only one request SHALL be outstanding at any time.
REQ-019 Buffering: a 2-entry FIFO of {PC, instr}. Credit = 2 - occupancy.
REQ-020 On iICacheVALID in REQ: push {fetchPC, iICacheDATA}; fetchPC += 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-021 After a push: next state is REQ if a credit remains after that cycle's pop, otherwise HOLD.
REQ-022 In HOLD, oICacheREQ=0; the block SHALL go to REQ in the cycle after a pop frees an entry.
REQ-023 oVALID SHALL equal FIFO not-empty; oINSTR and oPCADDR SHALL be driven from registered head storage.
REQ-024 Pop SHALL occur when oVALID=1 and iStall=0; a push and a pop in the same cycle SHALL both take effect.
REQ-025 Minimum latency: iICacheVALID in cycle N gives oVALID=1 with that word in cycle N+1.
REQ-026 iBranchTAKEN SHALL flush the FIFO (oVALID=0 next cycle) and set fetchPC={iBranchADDR[31:2],2'b00}.
REQ-027 Branch with no outstanding request: next state REQ, with the new address on oICacheADDR the next cycle.
REQ-028 Branch while a request is outstanding: go to DROP; DROP SHALL keep oICacheREQ=1 at the stale address and discard the data on iICacheVALID, then go to REQ.
REQ-029 Branch arriving in DROP SHALL update the target and remain in DROP.
REQ-030 iBranchTAKEN SHALL take priority over a simultaneous iICacheVALID push and pop; the pushed word SHALL be discarded, and fetchPC SHALL take the target, not +4.
REQ-031 iICacheVALID in IDLE or HOLD SHALL be ignored.

Reset
REQ-032 iRSTn=0 at a clock edge SHALL force: state IDLE, fetchPC=RESET_VECTOR, FIFO empty, oVALID=0, oICacheREQ=0, oICacheADDR=RESET_VECTOR, oPCADDR=0, oINSTR=NOP_INSTR.
REQ-033 Reset mid-request SHALL abandon that request; a late iICacheVALID SHALL be ignored by REQ-031.

Structure
REQ-034 FSM state encodings, NOP_INSTR and the RESET_VECTOR default SHALL live in the shared header alongside the decoded-op definitions.
REQ-035 The 2-entry FIFO SHALL be a separate sub-module, pip_fifo2, with push/pop/full/empty ports and 64-bit data.

Verification
REQ-036 Reset release with the cache answering after 1 cycle: first request at 0x0; oVALID with oPCADDR=0, then 4, then 8 on consecutive cycles.
REQ-037 iStall held high for 5 cycles: FIFO fills at 2, oICacheREQ drops (HOLD); release gives oPCADDR 0, 4, 8 with no gap or duplicate.
REQ-038 Branch to 0x100 with none outstanding: next cycle oICacheADDR=0x100 and oVALID=0; first output oPCADDR=0x100.
REQ-039 Branch to 0x200 while a request to 0x8 waits 3 cycles: the 0x8 word is never presented; the next request is 0x200.
REQ-040 Branch to 0x3 at fetchPC 0xFFFF_FFFC: fetch at 0x0, not 0x3; the sequential wrap 0xFFFF_FFFC -> 0x0 is checked separately.
REQ-041 iRSTn low during an outstanding request: all outputs take reset values next cycle; a stale iICacheVALID is ignored.
